// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer slice.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH = 32;
  localparam int unsigned TIMER_ECW   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import timer_pkg::*;
#(
  parameter int unsigned W = TIMER_ECW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes and an
// expiry pulse; per-edge priority is abort > load > start > pause > decrement.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH,
  parameter int unsigned ECW   = TIMER_ECW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_periodic,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic             done,
  output logic [ECW-1:0]   expire_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             expired_q, expired_d;
  logic             done_q, done_d;
  logic             load_take;
  logic             expire_fire;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      expired_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      expired_q  <= expired_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    periodic_d  = periodic_q;
    expired_d   = 1'b0;
    done_d      = done_q;
    load_take   = 1'b0;
    expire_fire = 1'b0;

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
      done_d  = 1'b0;
    end else if (load_valid && load_ready) begin
      load_take  = 1'b1;
      count_d    = load_value;
      reload_d   = load_value;
      periodic_d = load_periodic;
      done_d     = 1'b0;
      state_d    = ARMED;
    end else begin
      unique case (state_q)
        ARMED: if (start) state_d = RUN;
        DONE: begin
          if (start) begin
            state_d = RUN;
            count_d = reload_q;
            done_d  = 1'b0;
          end
        end
        RUN: begin
          if (!pause) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // count of 0 or 1 both expire here, so a zero load acts as 1
              expired_d   = 1'b1;
              expire_fire = 1'b1;
              if (periodic_q) begin
                count_d = (reload_q == '0) ? WIDTH'(1) : reload_q;
              end else begin
                count_d = '0;
                done_d  = 1'b1;
                state_d = DONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    load_ready = (state_q != RUN);
    busy       = (state_q == RUN);
  end

  sat_counter #(.W(ECW)) u_expire_cnt (
    .clk  (clk),
    .rst_n(rst),
    .clr_i(load_take),
    .inc_i(expire_fire),
    .cnt_o(expire_cnt)
  );

  assign count   = count_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (ECW=8 and ECW=2) driven in lockstep and
// compared every checked cycle against a flag-based behavioural model.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_value = '0;
  logic        load_periodic = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        abort = 1'b0;

  logic        load_ready, busy, expired, done;
  logic [31:0] count;
  logic [7:0]  expire_cnt;
  logic        load_ready2, busy2, expired2, done2;
  logic [31:0] count2;
  logic [1:0]  expire_cnt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(32), .ECW(8)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_periodic(load_periodic), .start(start),
    .pause(pause), .abort(abort), .count(count), .busy(busy),
    .expired(expired), .done(done), .expire_cnt(expire_cnt)
  );

  countdown_timer #(.WIDTH(32), .ECW(2)) dut2 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready2),
    .load_value(load_value), .load_periodic(load_periodic), .start(start),
    .pause(pause), .abort(abort), .count(count2), .busy(busy2),
    .expired(expired2), .done(done2), .expire_cnt(expire_cnt2)
  );

  // Behavioural model: a few flags plus an unbounded expiry tally
  int unsigned m_cnt, m_reload, m_ec;
  bit          m_per, m_armed, m_running, m_done, m_exp;

  logic [81:0] actv;
  assign actv = {count, busy, load_ready, expired, done, expire_cnt,
                 count2, busy2, load_ready2, expired2, done2, expire_cnt2};

  function automatic logic [81:0] expv();
    logic [7:0] e8;
    logic [1:0] e2;
    e8 = (m_ec > 255) ? 8'd255 : 8'(m_ec);
    e2 = (m_ec > 3) ? 2'd3 : 2'(m_ec);
    return {m_cnt, m_running, !m_running, m_exp, m_done, e8,
            m_cnt, m_running, !m_running, m_exp, m_done, e2};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_reload = 0; m_ec = 0;
    m_per = 0; m_armed = 0; m_running = 0; m_done = 0; m_exp = 0;
  endtask

  task automatic model_step();
    m_exp = 0;
    if (abort) begin
      m_running = 0; m_armed = 0; m_done = 0; m_cnt = 0;
    end else if (load_valid && !m_running) begin
      m_cnt = load_value; m_reload = load_value; m_per = load_periodic;
      m_ec = 0; m_done = 0; m_armed = 1;
    end else if (m_armed && start) begin
      m_armed = 0; m_running = 1;
    end else if (m_done && start) begin
      m_done = 0; m_running = 1; m_cnt = m_reload;
    end else if (m_running && !pause) begin
      if (m_cnt > 1) m_cnt = m_cnt - 1;
      else begin
        m_exp = 1;
        m_ec  = m_ec + 1;
        if (m_per) m_cnt = (m_reload == 0) ? 1 : m_reload;
        else begin
          m_cnt = 0; m_done = 1; m_running = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_load(input int unsigned v, input bit per);
    load_valid = 1'b1; load_value = v; load_periodic = per;
    tick();
    load_valid = 1'b0; load_periodic = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk); @(negedge clk);
    vectors++;
    if (actv !== expv()) begin
      $display("FAIL reset_init act=%h exp=%h", actv, expv()); miscompares++;
    end
    rst = 1'b1;
    do_load(20, 0);
    do_start();
    repeat (3) tick();
    vectors++;
    if (count !== 32'd17 || actv !== expv()) begin
      $display("FAIL reset_prerun act=%h exp=%h", actv, expv()); miscompares++;
    end
    rst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (actv !== expv() || load_ready !== 1'b1) begin
      $display("FAIL reset_async act=%h exp=%h", actv, expv()); miscompares++;
    end
    #1 rst = 1'b1;
    tick();
    vectors++;
    if (actv !== expv()) begin
      $display("FAIL reset_release act=%h exp=%h", actv, expv()); miscompares++;
    end
  endtask

  task automatic test_oneshot();
    do_load(5, 0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (actv !== expv()) begin
        $display("FAIL oneshot_cyc%0d act=%h exp=%h", i, actv, expv()); miscompares++;
      end
      tick();
    end
    vectors++;
    if (expired !== 1'b1 || done !== 1'b1 || count !== 32'd0 || busy !== 1'b0 || expire_cnt !== 8'd1) begin
      $display("FAIL oneshot_expiry act=%h exp=%h", actv, expv()); miscompares++;
    end
    tick();
    vectors++;
    if (expired !== 1'b0 || actv !== expv()) begin
      $display("FAIL oneshot_after act=%h exp=%h", actv, expv()); miscompares++;
    end
  endtask

  task automatic test_periodic();
    int pulses;
    pulses = 0;
    do_load(3, 1);
    do_start();
    for (int i = 0; i < 12; i++) begin
      tick();
      pulses += int'(expired);
      vectors++;
      if (actv !== expv() || load_ready !== 1'b0) begin
        $display("FAIL periodic_cyc%0d act=%h exp=%h", i, actv, expv()); miscompares++;
      end
    end
    vectors++;
    if (pulses != 4 || expire_cnt !== 8'd4) begin
      $display("FAIL periodic_pulses act=%0d/%0d exp=4/4", pulses, expire_cnt); miscompares++;
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_pause();
    do_load(4, 0);
    do_start();
    tick();
    pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (count !== 32'd3 || actv !== expv()) begin
        $display("FAIL pause_hold%0d act=%h exp=%h", i, actv, expv()); miscompares++;
      end
    end
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (actv !== expv()) begin
        $display("FAIL pause_run%0d act=%h exp=%h", i, actv, expv()); miscompares++;
      end
    end
    vectors++;
    if (expired !== 1'b1 || done !== 1'b1) begin
      $display("FAIL pause_expiry act=%b%b exp=11", expired, done); miscompares++;
    end
    do_start();
    vectors++;
    if (count !== 32'd4 || busy !== 1'b1 || done !== 1'b0 || actv !== expv()) begin
      $display("FAIL rerun_start act=%h exp=%h", actv, expv()); miscompares++;
    end
    repeat (4) tick();
    vectors++;
    if (expired !== 1'b1 || actv !== expv()) begin
      $display("FAIL rerun_expiry act=%h exp=%h", actv, expv()); miscompares++;
    end
  endtask

  task automatic test_abort();
    do_load(2, 0);
    do_start();
    tick();
    abort = 1'b1;
    tick();
    vectors++;
    if (expired !== 1'b0 || busy !== 1'b0 || count !== 32'd0 || done !== 1'b0 ||
        expire_cnt !== 8'd0 || actv !== expv()) begin
      $display("FAIL abort_expiry act=%h exp=%h", actv, expv()); miscompares++;
    end
    load_valid = 1'b1; load_value = 9;
    vectors++;
    if (load_ready !== 1'b1) begin
      $display("FAIL abort_ready act=%b exp=1", load_ready); miscompares++;
    end
    tick();
    load_valid = 1'b0; abort = 1'b0;
    vectors++;
    if (count !== 32'd0 || actv !== expv()) begin
      $display("FAIL abort_vs_load act=%h exp=%h", actv, expv()); miscompares++;
    end
  endtask

  task automatic test_ecw_sat();
    do_load(1, 1);
    do_start();
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (expired !== 1'b1 || actv !== expv()) begin
        $display("FAIL sat_cyc%0d act=%h exp=%h", i, actv, expv()); miscompares++;
      end
    end
    vectors++;
    if (expire_cnt2 !== 2'd3 || expire_cnt !== 8'd6) begin
      $display("FAIL sat_value act=%0d/%0d exp=3/6", expire_cnt2, expire_cnt); miscompares++;
    end
    load_valid = 1'b1; load_value = 77;
    vectors++;
    if (load_ready !== 1'b0) begin
      $display("FAIL run_ready act=%b exp=0", load_ready); miscompares++;
    end
    tick();
    load_valid = 1'b0;
    vectors++;
    if (count === 32'd77 || actv !== expv()) begin
      $display("FAIL run_load_blocked act=%h exp=%h", actv, expv()); miscompares++;
    end
    abort = 1'b1; tick(); abort = 1'b0;
    do_load(0, 0);
    do_start();
    tick();
    vectors++;
    if (expired !== 1'b1 || done !== 1'b1 || actv !== expv()) begin
      $display("FAIL zero_load act=%h exp=%h", actv, expv()); miscompares++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load_valid    = ($urandom_range(0, 5) == 0);
      load_value    = $urandom_range(0, 6);
      load_periodic = $urandom_range(0, 1) == 1;
      start         = ($urandom_range(0, 3) == 0);
      pause         = ($urandom_range(0, 4) == 0);
      abort         = ($urandom_range(0, 19) == 0);
      tick();
      vectors++;
      if (actv !== expv()) begin
        $display("FAIL random_cyc%0d act=%h exp=%h", i, actv, expv()); miscompares++;
      end
    end
    load_valid = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_abort();
    test_ecw_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
